// File: rtl/imm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// imm_seq_ctrl
//
// Purpose
//   Multicycle sequencer that owns the sign-extender format select in the
//   RISC-V core. It accepts one instruction per handshake from fetch and
//   decodes the opcode into an immediate format. It leaves one cycle for the
//   registered sign extender to settle, then steps EXEC / MEM / WB. Along the
//   way it drives the datapath strobes and counts retired instructions.
//
//   State flow:
//     IDLE -> DECODE -> [IMM_WAIT] -> EXEC -> [MEM] -> WB -> IDLE
//   DECODE or MEM may branch to TRAP. TRAP waits for i_trap_clr.
//
// Parameters
//   MEM_TIMEOUT  maximum number of MEM cycles spent waiting for i_mem_ack (>=1)
//   CNT_W        width of the retired-instruction counter
//   EXT_NONE     ext_sel code meaning "no immediate"
//
// Ports
//   i_clock        system clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_instr_valid  fetch presents i_instr
//   i_instr        32-bit instruction word
//   o_instr_ready  controller accepts an instruction (IDLE only)
//   o_ext_sel      immediate format to the sign extender (registered)
//   o_alu_src_imm  ALU operand B takes the immediate (EXEC cycle)
//   i_br_taken     branch compare result, sampled in EXEC
//   o_mem_req      memory request, held until ack or timeout
//   o_mem_we       1 = store, 0 = load; valid with o_mem_req
//   i_mem_ack      memory completion (ignored outside MEM)
//   o_reg_we       register-file write strobe (one WB cycle)
//   o_pc_we        PC update strobe (one WB cycle)
//   o_pc_sel       00 pc+4, 01 pc+imm, 10 rs1+imm; valid with o_pc_we
//   o_trap         illegal opcode or memory timeout; sticky until i_trap_clr
//   i_trap_clr     clears the trap and returns to IDLE
//   o_retired      count of instructions completed through WB (wraps)
// -----------------------------------------------------------------------------
module imm_seq_ctrl #(
    parameter int          MEM_TIMEOUT = 15,
    parameter int          CNT_W       = 16,
    parameter logic [3:0]  EXT_NONE    = 4'b1110
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_instr_valid,
    input  logic [31:0]      i_instr,
    output logic             o_instr_ready,
    output logic [3:0]       o_ext_sel,
    output logic             o_alu_src_imm,
    input  logic             i_br_taken,
    output logic             o_mem_req,
    output logic             o_mem_we,
    input  logic             i_mem_ack,
    output logic             o_reg_we,
    output logic             o_pc_we,
    output logic [1:0]       o_pc_sel,
    output logic             o_trap,
    input  logic             i_trap_clr,
    output logic [CNT_W-1:0] o_retired
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [3:0] EXT_I     = 4'd0;
    localparam logic [3:0] EXT_S     = 4'd1;
    localparam logic [3:0] EXT_B     = 4'd2;
    localparam logic [3:0] EXT_U     = 4'd3;
    localparam logic [3:0] EXT_J     = 4'd4;
    localparam logic [3:0] EXT_SHAMT = 4'd5;

    // Wait counter only has to hold 0 .. MEM_TIMEOUT-1.
    localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0]    WAIT_LAST = TW'(MEM_TIMEOUT - 1);
    localparam logic [TW-1:0]    WAIT_ONE  = TW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_IMM_WAIT,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t           r_state;
    logic [31:0]      r_ir;
    logic [3:0]       r_ext_sel;
    logic             r_instr_ready;
    logic             r_alu_src_imm;
    logic             r_mem_req;
    logic             r_mem_we;
    logic             r_reg_we;
    logic             r_pc_we;
    logic [1:0]       r_pc_sel;
    logic             r_trap;
    logic [TW-1:0]    r_wait_cnt;
    logic [CNT_W-1:0] r_retired;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [4:0] w_rd;
    logic       w_legal;
    logic [3:0] w_dec_ext;
    logic       w_is_reg;
    logic       w_is_store;
    logic       w_is_mem;
    logic       w_is_branch;
    logic [1:0] w_wb_pc_sel;
    logic       w_wb_reg_we;
    logic       w_unused_ir;

    assign w_opcode    = r_ir[6:0];
    assign w_rd        = r_ir[11:7];
    assign w_funct3    = r_ir[14:12];
    assign w_unused_ir = ^r_ir[31:15];

    assign w_is_reg    = (w_opcode == OP_REG);
    assign w_is_store  = (w_opcode == OP_STORE);
    assign w_is_mem    = (w_opcode == OP_LOAD) || w_is_store;
    assign w_is_branch = (w_opcode == OP_BRANCH);

    // Immediate format per opcode; unknown opcodes flag an illegal instruction.
    always_comb begin
        w_legal   = 1'b1;
        w_dec_ext = EXT_NONE;
        case (w_opcode)
            OP_IMM:            w_dec_ext = ((w_funct3 == 3'b001) || (w_funct3 == 3'b101))
                                           ? EXT_SHAMT : EXT_I;
            OP_LOAD, OP_JALR:  w_dec_ext = EXT_I;
            OP_STORE:          w_dec_ext = EXT_S;
            OP_BRANCH:         w_dec_ext = EXT_B;
            OP_LUI, OP_AUIPC:  w_dec_ext = EXT_U;
            OP_JAL:            w_dec_ext = EXT_J;
            OP_REG:            w_dec_ext = EXT_NONE;
            default:           w_legal   = 1'b0;
        endcase
    end

    // WB strobe values, loaded on the transition into WB. Branches always go
    // EXEC -> WB, so i_br_taken is consumed exactly on the EXEC cycle.
    always_comb begin
        w_wb_pc_sel = 2'b00;
        if (w_opcode == OP_JAL) begin
            w_wb_pc_sel = 2'b01;
        end else if (w_opcode == OP_JALR) begin
            w_wb_pc_sel = 2'b10;
        end else if (w_is_branch && i_br_taken) begin
            w_wb_pc_sel = 2'b01;
        end
    end

    assign w_wb_reg_we = !w_is_store && !w_is_branch && (w_rd != 5'd0);

    // State and all outputs are registered together; every output reflects
    // the state it belongs to in the same cycle.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_ir          <= '0;
            r_ext_sel     <= EXT_NONE;
            r_instr_ready <= 1'b1;
            r_alu_src_imm <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_reg_we      <= 1'b0;
            r_pc_we       <= 1'b0;
            r_pc_sel      <= 2'b00;
            r_trap        <= 1'b0;
            r_wait_cnt    <= '0;
            r_retired     <= '0;
        end else begin
            // Single-cycle strobes fall back low unless re-armed below.
            r_alu_src_imm <= 1'b0;
            r_reg_we      <= 1'b0;
            r_pc_we       <= 1'b0;
            r_pc_sel      <= 2'b00;

            case (r_state)
                S_IDLE: begin
                    if (i_instr_valid) begin
                        r_ir          <= i_instr;
                        r_instr_ready <= 1'b0;
                        r_state       <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    if (!w_legal) begin
                        r_trap  <= 1'b1;
                        r_state <= S_TRAP;
                    end else begin
                        r_ext_sel <= w_dec_ext;
                        // R-type has no immediate, so nothing to wait for.
                        r_state   <= w_is_reg ? S_EXEC : S_IMM_WAIT;
                    end
                end

                S_IMM_WAIT: begin
                    r_alu_src_imm <= 1'b1;
                    r_state       <= S_EXEC;
                end

                S_EXEC: begin
                    if (w_is_mem) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= w_is_store;
                        r_wait_cnt <= '0;
                        r_state    <= S_MEM;
                    end else begin
                        r_pc_we  <= 1'b1;
                        r_pc_sel <= w_wb_pc_sel;
                        r_reg_we <= w_wb_reg_we;
                        r_state  <= S_WB;
                    end
                end

                S_MEM: begin
                    // An ack on the last allowed cycle still completes.
                    if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_pc_we   <= 1'b1;
                        r_pc_sel  <= w_wb_pc_sel;
                        r_reg_we  <= w_wb_reg_we;
                        r_state   <= S_WB;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_trap    <= 1'b1;
                        r_state   <= S_TRAP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_ONE;
                    end
                end

                S_WB: begin
                    r_retired     <= r_retired + CNT_ONE;
                    r_instr_ready <= 1'b1;
                    r_state       <= S_IDLE;
                end

                S_TRAP: begin
                    // instr_ready stays low here, so a fetch presented in the
                    // clearing cycle is not taken.
                    if (i_trap_clr) begin
                        r_trap        <= 1'b0;
                        r_instr_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end

                default: begin
                    r_instr_ready <= 1'b1;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign o_instr_ready = r_instr_ready;
    assign o_ext_sel     = r_ext_sel;
    assign o_alu_src_imm = r_alu_src_imm;
    assign o_mem_req     = r_mem_req;
    assign o_mem_we      = r_mem_we;
    assign o_reg_we      = r_reg_we;
    assign o_pc_we       = r_pc_we;
    assign o_pc_sel      = r_pc_sel;
    assign o_trap        = r_trap;
    assign o_retired     = r_retired;

endmodule

// File: tb/tb_imm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imm_seq_ctrl
//   Directed vector table followed by randomized instructions. Each
//   transaction is reduced to a summary of what appeared on the outputs. That
//   summary is compared with an expectation from either the table or a
//   behavioural model of the instruction rules.
// -----------------------------------------------------------------------------
module tb_imm_seq_ctrl;

    localparam int         TO       = 15;
    localparam int         CW       = 4;
    localparam logic [3:0] EXT_NONE = 4'b1110;

    logic           clk;
    logic           i_reset;
    logic           i_instr_valid;
    logic [31:0]    i_instr;
    logic           o_instr_ready;
    logic [3:0]     o_ext_sel;
    logic           o_alu_src_imm;
    logic           i_br_taken;
    logic           o_mem_req;
    logic           o_mem_we;
    logic           i_mem_ack;
    logic           o_reg_we;
    logic           o_pc_we;
    logic [1:0]     o_pc_sel;
    logic           o_trap;
    logic           i_trap_clr;
    logic [CW-1:0]  o_retired;

    imm_seq_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW), .EXT_NONE(EXT_NONE)) dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_instr_valid (i_instr_valid),
        .i_instr       (i_instr),
        .o_instr_ready (o_instr_ready),
        .o_ext_sel     (o_ext_sel),
        .o_alu_src_imm (o_alu_src_imm),
        .i_br_taken    (i_br_taken),
        .o_mem_req     (o_mem_req),
        .o_mem_we      (o_mem_we),
        .i_mem_ack     (i_mem_ack),
        .o_reg_we      (o_reg_we),
        .o_pc_we       (o_pc_we),
        .o_pc_sel      (o_pc_sel),
        .o_trap        (o_trap),
        .i_trap_clr    (i_trap_clr),
        .o_retired     (o_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-transaction summary: cycle indices count the accept cycle as 1.
    typedef struct {
        int ext;       // ext_sel seen on cycle 3
        int wb;        // cycle of the pc_we strobe, -1 if none
        int pcwe_n;
        int pc_sel;
        int reg_n;
        int memreq_n;
        int memwe_n;
        int alu_n;
        int trap;
        int retired;
    } obs_t;

    typedef struct {
        logic [31:0] ins;
        bit          br;
        int          k;        // MEM cycle carrying the ack, 0 = never
        int          ext;
        int          wb;
        int          pc_sel;
        int          reg_n;
        int          memreq;
        int          memwe;
        int          alu;
        int          trap;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int model_ret = 0;
    int prev_ext  = 14;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_obs(input string tag, input obs_t e, input obs_t o);
        chk({tag, "_ext"},     o.ext,      e.ext);
        chk({tag, "_wb"},      o.wb,       e.wb);
        chk({tag, "_pcwe_n"},  o.pcwe_n,   e.pcwe_n);
        chk({tag, "_pc_sel"},  o.pc_sel,   e.pc_sel);
        chk({tag, "_reg_n"},   o.reg_n,    e.reg_n);
        chk({tag, "_memreq"},  o.memreq_n, e.memreq_n);
        chk({tag, "_memwe"},   o.memwe_n,  e.memwe_n);
        chk({tag, "_alu"},     o.alu_n,    e.alu_n);
        chk({tag, "_trap"},    o.trap,     e.trap);
        chk({tag, "_retired"}, o.retired,  e.retired);
    endtask

    // Behavioural model: outcome of one instruction from the opcode rules
    // and the latency rules (R 4, I/U/J/B 5, memory 5 + ack cycle).
    function automatic obs_t model(input logic [31:0] ins, input bit br, input int k);
        obs_t e;
        int   opc;
        int   f3;
        int   rd;
        bit   legal;
        bit   is_r;
        bit   is_mem;
        bit   is_st;
        bit   is_br;
        bit   done;
        opc = int'(ins[6:0]);
        f3  = int'(ins[14:12]);
        rd  = int'(ins[11:7]);
        e = '{default: 0};
        legal = 1'b1;
        is_r = 1'b0; is_mem = 1'b0; is_st = 1'b0; is_br = 1'b0;
        case (opc)
            'h13: e.ext = (f3 == 1 || f3 == 5) ? 5 : 0;
            'h03: begin e.ext = 0; is_mem = 1'b1; end
            'h67: e.ext = 0;
            'h23: begin e.ext = 1; is_mem = 1'b1; is_st = 1'b1; end
            'h63: begin e.ext = 2; is_br = 1'b1; end
            'h37, 'h17: e.ext = 3;
            'h6F: e.ext = 4;
            'h33: begin e.ext = 14; is_r = 1'b1; end
            default: begin legal = 1'b0; e.ext = prev_ext; end
        endcase
        done = legal && (!is_mem || (k >= 1 && k <= TO));
        e.trap     = done ? 0 : 1;
        e.alu_n    = (legal && !is_r) ? 1 : 0;
        e.memreq_n = !legal ? 0 : (!is_mem ? 0 : (done ? k : TO));
        e.memwe_n  = is_st ? e.memreq_n : 0;
        e.wb       = !done ? -1 : (is_r ? 4 : (is_mem ? 5 + k : 5));
        e.pcwe_n   = done ? 1 : 0;
        e.reg_n    = (done && !is_st && !is_br && rd != 0) ? 1 : 0;
        if (!done)            e.pc_sel = 0;
        else if (opc == 'h6F) e.pc_sel = 1;
        else if (opc == 'h67) e.pc_sel = 2;
        else if (is_br && br) e.pc_sel = 1;
        else                  e.pc_sel = 0;
        e.retired = done ? (model_ret + 1) % (1 << CW) : model_ret;
        return e;
    endfunction

    // Drive one instruction and summarise what the outputs did. Starts and
    // ends on a falling edge.
    task automatic run_txn(input logic [31:0] ins, input bit br, input int k, output obs_t o);
        int n;
        bit done;
        o = '{default: 0};
        o.wb  = -1;
        o.ext = -1;
        n = 0;
        while (!o_instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", int'(o_instr_ready), 1);
        i_instr       = ins;
        i_instr_valid = 1'b1;
        i_br_taken    = 1'($urandom);
        i_mem_ack     = 1'($urandom);
        @(negedge clk);
        i_instr_valid = 1'b0;
        i_instr       = $urandom;   // ir must already hold the instruction
        n    = 2;
        done = 1'b0;
        while (n <= 40 && !done) begin
            if (n == 3) o.ext = int'(o_ext_sel);
            if (o_pc_we) begin
                o.pcwe_n++;
                if (o.wb < 0) begin
                    o.wb     = n;
                    o.pc_sel = int'(o_pc_sel);
                end
            end
            if (o_reg_we)      o.reg_n++;
            if (o_mem_req)     o.memreq_n++;
            if (o_mem_req && o_mem_we) o.memwe_n++;
            if (o_alu_src_imm) o.alu_n++;
            if (o_trap) begin
                o.trap = 1;
                done   = 1'b1;
            end
            if (n > 2 && o_instr_ready) done = 1'b1;
            if (!done) begin
                // EXEC of an immediate instruction is cycle 4; br_taken is
                // noise on every other cycle, ack is noise before MEM.
                i_br_taken = (n == 4) ? br : 1'($urandom);
                if (k > 0 && n == 4 + k) i_mem_ack = 1'b1;
                else if (n < 5)          i_mem_ack = 1'($urandom);
                else                     i_mem_ack = 1'b0;
                @(negedge clk);
                n++;
            end
        end
        if (!done) chk("txn_budget", 0, 1);
        o.retired  = int'(o_retired);
        i_mem_ack  = 1'b0;
        i_br_taken = 1'b0;
    endtask

    task automatic clear_trap();
        @(negedge clk);
        chk("trap_sticky", int'(o_trap), 1);
        chk("trap_not_ready", int'(o_instr_ready), 0);
        i_trap_clr    = 1'b1;
        i_instr_valid = 1'b1;
        i_instr       = 32'h00000013;
        @(negedge clk);
        i_trap_clr    = 1'b0;
        i_instr_valid = 1'b0;
        chk("trap_cleared", int'(o_trap), 0);
        chk("clr_idle_ready", int'(o_instr_ready), 1);
        @(negedge clk);
        chk("clr_no_accept", int'(o_instr_ready), 1);
    endtask

    vec_t tbl[$];

    initial begin
        obs_t o;
        obs_t e;
        logic [6:0]  legal_ops[9];
        logic [6:0]  bad_ops[4];
        logic [31:0] rnd;
        logic [6:0]  opc;

        legal_ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        bad_ops   = '{7'h7F, 7'h0B, 7'h00, 7'h5B};

        //              ins           br  k  ext wb pcs reg mr mw alu trap
        tbl.push_back('{32'h00500093, 0,  0, 0,  5, 0,  1,  0, 0, 1,  0}); // addi
        tbl.push_back('{32'h002081B3, 0,  0, 14, 4, 0,  1,  0, 0, 0,  0}); // add
        tbl.push_back('{32'h123450B7, 0,  0, 3,  5, 0,  1,  0, 0, 1,  0}); // lui
        tbl.push_back('{32'h0020A223, 0,  3, 1,  8, 0,  0,  3, 3, 1,  0}); // sw ack 3
        tbl.push_back('{32'h0000A103, 0,  0, 0, -1, 0,  0, 15, 0, 1,  1}); // lw timeout
        tbl.push_back('{32'h0000A103, 0, 15, 0, 20, 0,  1, 15, 0, 1,  0}); // lw ack 15
        tbl.push_back('{32'h00000063, 1,  0, 2,  5, 1,  0,  0, 0, 1,  0}); // beq taken
        tbl.push_back('{32'h00208463, 0,  0, 2,  5, 0,  0,  0, 0, 1,  0}); // beq not taken
        tbl.push_back('{32'h008000EF, 0,  0, 4,  5, 1,  1,  0, 0, 1,  0}); // jal ra
        tbl.push_back('{32'h000080E7, 0,  0, 0,  5, 2,  1,  0, 0, 1,  0}); // jalr ra
        tbl.push_back('{32'h0000007F, 0,  0, 0, -1, 0,  0,  0, 0, 0,  1}); // illegal
        tbl.push_back('{32'h00109093, 0,  0, 5,  5, 0,  1,  0, 0, 1,  0}); // slli
        tbl.push_back('{32'h4010D093, 0,  0, 5,  5, 0,  1,  0, 0, 1,  0}); // srai
        tbl.push_back('{32'h00001097, 0,  0, 3,  5, 0,  1,  0, 0, 1,  0}); // auipc
        tbl.push_back('{32'h00000013, 0,  0, 0,  5, 0,  0,  0, 0, 1,  0}); // addi x0
        tbl.push_back('{32'h0020A223, 0,  1, 1,  6, 0,  0,  1, 1, 1,  0}); // sw ack 1
        tbl.push_back('{32'h0000000B, 0,  0, 1, -1, 0,  0,  0, 0, 0,  1}); // illegal, ext held

        i_reset       = 1'b1;
        i_instr_valid = 1'b0;
        i_instr       = '0;
        i_br_taken    = 1'b0;
        i_mem_ack     = 1'b0;
        i_trap_clr    = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_ready",   int'(o_instr_ready), 1);
        chk("rst_ext",     int'(o_ext_sel), 14);
        chk("rst_retired", int'(o_retired), 0);
        chk("rst_memreq",  int'(o_mem_req), 0);
        chk("rst_pcwe",    int'(o_pc_we), 0);
        chk("rst_regwe",   int'(o_reg_we), 0);
        chk("rst_trap",    int'(o_trap), 0);
        chk("rst_alu",     int'(o_alu_src_imm), 0);
        i_reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            e          = '{default: 0};
            e.ext      = tbl[i].ext;
            e.wb       = tbl[i].wb;
            e.pcwe_n   = (tbl[i].wb > 0) ? 1 : 0;
            e.pc_sel   = tbl[i].pc_sel;
            e.reg_n    = tbl[i].reg_n;
            e.memreq_n = tbl[i].memreq;
            e.memwe_n  = tbl[i].memwe;
            e.alu_n    = tbl[i].alu;
            e.trap     = tbl[i].trap;
            e.retired  = tbl[i].trap ? model_ret : (model_ret + 1) % (1 << CW);
            run_txn(tbl[i].ins, tbl[i].br, tbl[i].k, o);
            $display("vec %0d ins=%08h ext=%0d wb=%0d pc_sel=%0d trap=%0d retired=%0d",
                     i, tbl[i].ins, o.ext, o.wb, o.pc_sel, o.trap, o.retired);
            check_obs($sformatf("vec%0d", i), e, o);
            model_ret = e.retired;
            prev_ext  = e.ext;
            if (tbl[i].trap != 0) clear_trap();
        end

        // Reset while a load waits in MEM.
        i_instr       = 32'h0000A103;
        i_instr_valid = 1'b1;
        @(negedge clk);
        i_instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_mem_req", int'(o_mem_req), 1);
        i_reset = 1'b1;
        #1;
        chk("async_memreq",  int'(o_mem_req), 0);
        chk("async_memwe",   int'(o_mem_we), 0);
        chk("async_ext",     int'(o_ext_sel), 14);
        chk("async_retired", int'(o_retired), 0);
        chk("async_ready",   int'(o_instr_ready), 1);
        chk("async_trap",    int'(o_trap), 0);
        $display("reset in MEM: mem_req=%0d ext=%0d retired=%0d", o_mem_req, o_ext_sel, o_retired);
        @(negedge clk);
        i_reset   = 1'b0;
        model_ret = 0;
        prev_ext  = 14;
        @(negedge clk);

        // Sixteen completions wrap the 4-bit counter back to zero.
        for (int i = 0; i < 16; i++) begin
            run_txn(32'h00100093, 1'b0, 0, o);
            $display("wrap %0d retired=%0d", i, o.retired);
            chk($sformatf("wrap%0d_retired", i), o.retired, (i + 1) % 16);
        end
        model_ret = 0;
        prev_ext  = 0;

        for (int t = 0; t < 70; t++) begin
            bit br;
            int k;
            rnd = $urandom;
            if ($urandom_range(0, 9) == 0) opc = bad_ops[$urandom_range(0, 3)];
            else                           opc = legal_ops[$urandom_range(0, 8)];
            rnd[6:0] = opc;
            br = 1'($urandom);
            k  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
            e  = model(rnd, br, k);
            run_txn(rnd, br, k, o);
            $display("rnd %0d ins=%08h br=%0d k=%0d ext=%0d wb=%0d pc_sel=%0d trap=%0d retired=%0d",
                     t, rnd, br, k, o.ext, o.wb, o.pc_sel, o.trap, o.retired);
            check_obs($sformatf("rnd%0d", t), e, o);
            model_ret = e.retired;
            prev_ext  = e.ext;
            if (e.trap != 0) clear_trap();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
